// File: rtl/game_pkg.sv
// Shared definitions for the dinosaur-runner game-flow controller:
// the game state encoding, the per-state output flags, the speed width and
// the default timing values also used by the obstacle updater.
package game_pkg;

  typedef enum logic [1:0] {
    TITLE = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DEAD  = 2'd3
  } game_state_t;

  // Levels handed to the object-update blocks, one bundle per state.
  typedef struct packed {
    logic start;
    logic pause;
    logic game_over;
  } game_flags_t;

  localparam int SPEED_W = 3;

  localparam int SCORE_PERIOD_DEF = 30;
  localparam int SPEED_STEP_DEF   = 100;
  localparam int SPEED_MAX_DEF    = 7;
  localparam int DEAD_HOLD_DEF    = 90;
  localparam int SCORE_W_DEF      = 14;

  // Bits needed for a counter running 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Output levels presented while the game sits in state s.
  function automatic game_flags_t state_flags(input game_state_t s);
    game_flags_t f;
    f = '0;
    case (s)
      RUN:     f.start = 1'b1;
      PAUSE:   begin f.start = 1'b1; f.pause = 1'b1; end
      DEAD:    begin f.start = 1'b1; f.pause = 1'b1; f.game_over = 1'b1; end
      default: f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Button/collision inputs and game-flow outputs of game_sequencer.
// master: the board side driving buttons and reading the flow levels.
// slave:  the game_sequencer itself.
interface game_sequencer_if
  import game_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEF
);

  logic               jump;
  logic               pause_btn;
  logic               hit;
  logic               start;
  logic               pause;
  logic               game_over;
  logic [SCORE_W-1:0] score;
  logic [SPEED_W-1:0] speed;
  logic [SCORE_W-1:0] hiscore;

  modport master (
    output jump, pause_btn, hit,
    input  start, pause, game_over, score, speed, hiscore
  );

  modport slave (
    input  jump, pause_btn, hit,
    output start, pause, game_over, score, speed, hiscore
  );

endinterface

// File: rtl/game_sequencer_btn_press.sv
// Falling-edge detector for an active-low button level: press is high for
// the single tick where the previous level was 1 and the current level is 0.
module btn_press (
  input  logic clk3,
  input  logic reset,
  input  logic level,
  output logic press
);

  logic prev;

  // Remember last tick's button level; released (1) out of reset.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk3 or posedge reset) begin
    if (reset) prev <= 1'b1;
    else       prev <= level;
  end

  // NOTE: the pulse is combinational so the consumer acts on the same edge
  // that samples the press; registering it would add a tick of latency.
  assign press = prev & ~level;

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: TITLE -> RUN -> PAUSE/DEAD -> TITLE, plus running
// score and speed level on the clk3 game tick.
// Optional feature: define GAME_HISCORE_EN to build the hiscore register;
// otherwise hiscore is tied to 0.
module game_sequencer
  import game_pkg::*;
#(
  parameter int SCORE_PERIOD = SCORE_PERIOD_DEF,
  parameter int SPEED_STEP   = SPEED_STEP_DEF,
  parameter int SPEED_MAX    = SPEED_MAX_DEF,
  parameter int DEAD_HOLD    = DEAD_HOLD_DEF,
  parameter int SCORE_W      = SCORE_W_DEF
) (
  input logic            clk3,
  input logic            reset,
  game_sequencer_if.slave bus
);

  localparam int TICK_W = cnt_width(SCORE_PERIOD);
  localparam int STEP_W = cnt_width(SPEED_STEP);
  localparam int HOLD_W = cnt_width(DEAD_HOLD + 1);

  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(SCORE_PERIOD - 1);
  localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(SPEED_STEP - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LIM  = HOLD_W'(DEAD_HOLD);
  localparam logic [SPEED_W-1:0] SPEED_LIM = SPEED_W'(SPEED_MAX);
  localparam logic [SCORE_W-1:0] SCORE_TOP = '1;

  game_state_t        state;
  game_flags_t        flags;
  logic [TICK_W-1:0]  tick_cnt;
  logic [STEP_W-1:0]  step_cnt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [SCORE_W-1:0] score_q;
  logic [SPEED_W-1:0] speed_q;

  logic jump_press;
  logic pause_press;

  btn_press u_jump_press (
    .clk3  (clk3),
    .reset (reset),
    .level (bus.jump),
    .press (jump_press)
  );

  btn_press u_pause_press (
    .clk3  (clk3),
    .reset (reset),
    .level (bus.pause_btn),
    .press (pause_press)
  );

  // Game-flow FSM with registered flags, score/speed and the three counters.
  always_ff @(posedge clk3 or posedge reset) begin
    if (reset) begin
      state    <= TITLE;
      flags    <= state_flags(TITLE);
      tick_cnt <= '0;
      step_cnt <= '0;
      hold_cnt <= '0;
      score_q  <= '0;
      speed_q  <= '0;
    end else begin
      case (state)
        TITLE: begin
          if (jump_press) begin
            state    <= RUN;
            flags    <= state_flags(RUN);
            tick_cnt <= '0;
            step_cnt <= '0;
            score_q  <= '0;
            speed_q  <= '0;
          end
        end

        RUN: begin
          // A collision beats a pause press and any score increment.
          if (bus.hit) begin
            state    <= DEAD;
            flags    <= state_flags(DEAD);
            hold_cnt <= '0;
          end else if (pause_press) begin
            state <= PAUSE;
            flags <= state_flags(PAUSE);
          end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            // Once the score is pinned at all-ones, speed progression stops too.
            if (score_q != SCORE_TOP) begin
              score_q <= score_q + SCORE_W'(1);
              if (step_cnt == STEP_LAST) begin
                step_cnt <= '0;
                if (speed_q < SPEED_LIM) speed_q <= speed_q + SPEED_W'(1);
              end else begin
                step_cnt <= step_cnt + STEP_W'(1);
              end
            end
          end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end

        PAUSE: begin
          if (pause_press) begin
            state <= RUN;
            flags <= state_flags(RUN);
          end
        end

        DEAD: begin
          // Restart presses before the hold expires are simply dropped.
          if (hold_cnt < HOLD_LIM) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end else if (jump_press) begin
            state <= TITLE;
            flags <= state_flags(TITLE);
          end
        end

        default: begin
          state <= TITLE;
          flags <= state_flags(TITLE);
        end
      endcase
    end
  end

  assign bus.start     = flags.start;
  assign bus.pause     = flags.pause;
  assign bus.game_over = flags.game_over;
  assign bus.score     = score_q;
  assign bus.speed     = speed_q;

`ifdef GAME_HISCORE_EN
  logic [SCORE_W-1:0] hiscore_q;

  // Capture a new best score on the collision edge out of RUN.
  always_ff @(posedge clk3 or posedge reset) begin
    if (reset) begin
      hiscore_q <= '0;
    end else if (state == RUN && bus.hit && score_q > hiscore_q) begin
      hiscore_q <= score_q;
    end
  end

  assign bus.hiscore = hiscore_q;
`else
  assign bus.hiscore = '0;
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed scenarios plus a random
// soak, all compared every tick against a behavioural model that tracks
// counted RUN ticks and derives score/speed arithmetically.
module tb_game_sequencer;

  localparam int SP = 4;
  localparam int SS = 3;
  localparam int SM = 7;
  localparam int DH = 5;
  localparam int SW = 14;
  localparam int SCORE_SAT = (1 << SW) - 1;

  localparam int M_TITLE = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DEAD  = 3;

  logic clk3 = 1'b0;
  logic reset;

  always #5 clk3 = ~clk3;

  game_sequencer_if #(.SCORE_W(SW)) gif ();

  game_sequencer #(
    .SCORE_PERIOD (SP),
    .SPEED_STEP   (SS),
    .SPEED_MAX    (SM),
    .DEAD_HOLD    (DH),
    .SCORE_W      (SW)
  ) dut (
    .clk3  (clk3),
    .reset (reset),
    .bus   (gif.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  int m_mode;
  int m_run_ticks;
  int m_dead_ticks;
  int m_hi;
  bit m_jprev;
  bit m_pprev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_score();
    int s;
    s = m_run_ticks / SP;
    return (s > SCORE_SAT) ? SCORE_SAT : s;
  endfunction

  function automatic int exp_speed();
    int v;
    v = exp_score() / SS;
    return (v > SM) ? SM : v;
  endfunction

  function automatic int exp_flags();
    case (m_mode)
      M_RUN:   return 3'b100;
      M_PAUSE: return 3'b110;
      M_DEAD:  return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic int exp_hi();
`ifdef GAME_HISCORE_EN
    return m_hi;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_mode       = M_TITLE;
    m_run_ticks  = 0;
    m_dead_ticks = 0;
    m_hi         = 0;
    m_jprev      = 1'b1;
    m_pprev      = 1'b1;
  endtask

  task automatic model_step(input bit j, input bit p, input bit h);
    bit jp, pp;
    jp = m_jprev && !j;
    pp = m_pprev && !p;
    m_jprev = j;
    m_pprev = p;
    case (m_mode)
      M_TITLE: if (jp) begin m_mode = M_RUN; m_run_ticks = 0; end
      M_RUN: begin
        if (h) begin
          if (exp_score() > m_hi) m_hi = exp_score();
          m_mode = M_DEAD;
          m_dead_ticks = 0;
        end else if (pp) begin
          m_mode = M_PAUSE;
        end else begin
          m_run_ticks++;
        end
      end
      M_PAUSE: if (pp) m_mode = M_RUN;
      default: begin
        if (m_dead_ticks < DH) m_dead_ticks++;
        else if (jp) m_mode = M_TITLE;
      end
    endcase
  endtask

  task automatic compare_all();
    check("flags",   32'({gif.start, gif.pause, gif.game_over}), 32'(exp_flags()));
    check("score",   32'(gif.score),   32'(exp_score()));
    check("speed",   32'(gif.speed),   32'(exp_speed()));
    check("hiscore", 32'(gif.hiscore), 32'(exp_hi()));
  endtask

  // One game tick: drive levels, let the edge happen, update model, compare.
  task automatic tick(input bit j, input bit p, input bit h);
    gif.jump      = j;
    gif.pause_btn = p;
    gif.hit       = h;
    @(posedge clk3);
    model_step(j, p, h);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    gif.jump      = 1'b1;
    gif.pause_btn = 1'b1;
    gif.hit       = 1'b0;
    reset         = 1'b1;
    model_reset();
    @(negedge clk3);
    @(negedge clk3);
    compare_all();
    reset = 1'b0;
  endtask

  // Run (buttons released) until the model score reaches n, bounded.
  task automatic run_until(input int n);
    int budget;
    budget = 400;
    while (exp_score() < n && budget > 0) begin
      tick(1, 1, 0);
      budget--;
    end
    check("run_until", 32'(gif.score), 32'(n));
  endtask

  task automatic start_game();
    tick(0, 1, 0);
    tick(1, 1, 0);
  endtask

  task automatic die_and_return();
    tick(1, 1, 1);
    repeat (DH) tick(1, 1, 0);
    tick(0, 1, 0);
    check("back_to_title", 32'({gif.start, gif.pause, gif.game_over}), 32'(3'b000));
    tick(1, 1, 0);
  endtask

  initial begin
    int saved;
    bit rj, rp;

    // Reset, then hold jump: one RUN entry, no further transitions.
    do_reset();
    check("reset_flags", 32'({gif.start, gif.pause, gif.game_over}), 32'(3'b000));
    repeat (10) tick(0, 1, 0);
    check("run_after_hold", 32'({gif.start, gif.pause}), 32'(2'b10));
    tick(1, 1, 0);
    repeat (30) tick(1, 1, 0);
    check("score_at_40", 32'(gif.score), 32'd10);
    check("speed_at_40", 32'(gif.speed), 32'd3);
    repeat (60) tick(1, 1, 0);
    check("speed_saturated", 32'(gif.speed), 32'(SM));

    // Collision and pause press together on a score-wrap tick.
    for (int i = 0; i < SP && (m_run_ticks % SP) != SP - 1; i++) tick(1, 1, 0);
    saved = 32'(gif.score);
    tick(1, 0, 1);
    check("hit_beats_pause", 32'({gif.start, gif.pause, gif.game_over}), 32'(3'b111));
    check("hit_no_increment", 32'(gif.score), 32'(saved));
    tick(1, 1, 0);
    tick(1, 1, 0);
    tick(0, 1, 0);
    check("early_jump_ignored", 32'(gif.game_over), 32'd1);
    tick(1, 1, 0);
    tick(1, 1, 0);
    tick(0, 1, 0);
    check("late_jump_title", 32'({gif.start, gif.game_over}), 32'(2'b00));
    tick(1, 1, 0);
    check("score_kept_in_title", 32'(gif.score), 32'(saved));

    // Pause at score 2; jump/hit ignored; counters resume from held values.
    start_game();
    run_until(2);
    tick(1, 0, 0);
    check("paused", 32'(gif.pause), 32'd1);
    for (int i = 0; i < 20; i++) tick((i % 3) != 0, 1, (i % 5) == 0);
    check("pause_score_held", 32'(gif.score), 32'd2);
    tick(1, 0, 0);
    check("resumed", 32'({gif.start, gif.pause}), 32'(2'b10));
    repeat (SP - 1) tick(1, 1, 0);
    check("resume_before_wrap", 32'(gif.score), 32'd2);
    tick(1, 1, 0);
    check("resume_wrap", 32'(gif.score), 32'd3);

    // Best score tracking from a fresh reset.
    do_reset();
    start_game();
    run_until(5);
    die_and_return();
`ifdef GAME_HISCORE_EN
    check("hiscore_first", 32'(gif.hiscore), 32'd5);
`else
    check("hiscore_tied", 32'(gif.hiscore), 32'd0);
`endif
    start_game();
    run_until(3);
    die_and_return();
`ifdef GAME_HISCORE_EN
    check("hiscore_kept", 32'(gif.hiscore), 32'd5);
`else
    check("hiscore_tied2", 32'(gif.hiscore), 32'd0);
`endif

    // Asynchronous reset in the middle of a run.
    start_game();
    run_until(9);
    #2;
    reset = 1'b1;
    #1;
    check("async_flags", 32'({gif.start, gif.pause, gif.game_over}), 32'(3'b000));
    check("async_score", 32'(gif.score), 32'd0);
    check("async_speed", 32'(gif.speed), 32'd0);
    check("async_hiscore", 32'(gif.hiscore), 32'd0);
    gif.jump      = 1'b1;
    gif.pause_btn = 1'b1;
    gif.hit       = 1'b0;
    model_reset();
    @(negedge clk3);
    reset = 1'b0;

    // Random soak.
    rj = 1'b1;
    rp = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(3) == 0)  rj = ~rj;
      if ($urandom_range(15) == 0) rp = ~rp;
      tick(rj, rp, $urandom_range(24) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
